// File: rtl/plic_pkg.sv
`default_nettype none
// ============================================================================
// plic_pkg : shared PLIC gateway defaults and state encoding | rev 1.0
// ============================================================================
package plic_pkg;

  localparam int NUM_SRC_DEF     = 32;
  localparam int ID_WIDTH_DEF    = 5;
  localparam int CNT_WIDTH_DEF   = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    INFL = 2'd2
  } gw_state_e;

endpackage : plic_pkg
`default_nettype wire

// File: rtl/plic_gateway_cell.sv
`default_nettype none
// ============================================================================
// plic_gateway_cell : one source's gateway FSM, edge counter and overflow flag | rev 1.0
// ============================================================================
module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 tm_i,
  input  logic [CNT_WIDTH-1:0] tnm_i,
  input  logic                 s_i,
  input  logic                 e_i,
  input  logic                 clam_i,
  input  logic                 comp_i,
  output logic                 pend_o,
  output logic                 infl_o,
  output logic                 ovf_o
);

  gw_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 pend_q, infl_q;
  logic                 req;
  logic                 take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    req     = tm_i ? (e_i || (cnt_q != '0)) : s_i;
    take    = 1'b0;

    case (state_q)
      IDLE: if (en_i && req) begin
        state_d = PEND;
        take    = 1'b1;
      end
      PEND: if (clam_i) state_d = INFL;
      INFL: if (comp_i) begin
        state_d = IDLE;
        ovf_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // The forwarded request consumes a same-cycle edge before any queued one.
    if (!tm_i) begin
      cnt_d = '0;
    end else if (take) begin
      if (!e_i) cnt_d = cnt_q - 1'b1;
    end else if (e_i) begin
      if (cnt_q >= tnm_i) ovf_d = 1'b1;
      else                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pend_q  <= (state_d == PEND);
      infl_q  <= (state_d == INFL);
    end
  end

  assign pend_o = pend_q;
  assign infl_o = infl_q;
  assign ovf_o  = ovf_q;

endmodule : plic_gateway_cell
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
// plic_gateway : synchroniser, edge detect and per-source gateway cell array | rev 1.0
// ============================================================================
module plic_gateway
  import plic_pkg::*;
#(
  parameter int NUM_SRC     = NUM_SRC_DEF,
  parameter int ID_WIDTH    = ID_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NUM_SRC-1:0]   tm_i,
  input  logic [CNT_WIDTH-1:0] tnm_i,
  input  logic [NUM_SRC-1:0]   irq_i,
  input  logic                 clam_i,
  input  logic [ID_WIDTH-1:0]  clam_id_i,
  input  logic                 comp_i,
  input  logic [ID_WIDTH-1:0]  comp_id_i,
  output logic [NUM_SRC-1:0]   pend_o,
  output logic [NUM_SRC-1:0]   infl_o,
  output logic [NUM_SRC-1:0]   ovf_o
);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_d_q;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] e;
  logic               unused_src0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  assign e = s & ~s_d_q;

  // Source 0 is reserved: outputs tied low and ID 0 never decodes to a cell.
  assign pend_o[0]   = 1'b0;
  assign infl_o[0]   = 1'b0;
  assign ovf_o[0]    = 1'b0;
  assign unused_src0 = ^{tm_i[0], e[0]};

  for (genvar i = 1; i < NUM_SRC; i++) begin : g_src
    plic_gateway_cell #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .tm_i   (tm_i[i]),
      .tnm_i  (tnm_i),
      .s_i    (s[i]),
      .e_i    (e[i]),
      .clam_i (clam_i && (clam_id_i == ID_WIDTH'(i))),
      .comp_i (comp_i && (comp_id_i == ID_WIDTH'(i))),
      .pend_o (pend_o[i]),
      .infl_o (infl_o[i]),
      .ovf_o  (ovf_o[i])
    );
  end : g_src

endmodule : plic_gateway
`default_nettype wire
